// File: rtl/led7seg_pkg.sv
// Shared types and constants for the 8-digit 74HC595 scan scheduler.
// LED7SEG_DIM_EN adds the BLANK state used by brightness dimming.
package led7seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam logic [7:0]  BLANK_CODE_DEFAULT = 8'hFF;

`ifdef LED7SEG_DIM_EN
  typedef enum logic [1:0] {IDLE, WAIT, SEND, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;
`endif

  // Word handed to the 74HC595 controller: segments high byte, digit select low byte.
  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
  } word_t;

  function automatic logic [7:0] onehot8(input logic [IDX_W-1:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/led7seg_tick_gen.sv
// Slot-rate divider: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
module led7seg_tick_gen #(
  parameter int unsigned PERIOD = 15625,
  parameter int unsigned CNT_W  = $clog2(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             tick_c,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  assign tick_c = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led7seg_scan_scheduler.sv
// Double-buffered frame scanner driving the 74HC595 seven-segment controller.
// Optional build macro LED7SEG_DIM_EN adds the bright[2:0] dimming input.
module led7seg_scan_scheduler
  import led7seg_pkg::*;
#(
  parameter int unsigned DIGIT_PERIOD = 15625,
  parameter logic [7:0]  BLANK_CODE   = BLANK_CODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
`ifdef LED7SEG_DIM_EN
  input  logic [2:0]  bright,
`endif
  input  logic [63:0] frame_seg,
  input  logic [7:0]  blank_mask,
  input  logic        frame_vld,
  output logic        frame_rdy,
  output logic [15:0] dat,
  output logic        vld,
  input  logic        rdy,
  output logic [2:0]  digit_idx,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

  state_t             state_q, state_d;
  logic [63:0]        active_q, active_d;
  logic [63:0]        shadow_q, shadow_d;
  logic [15:0]        dat_d;
  logic               vld_d, done_d, ovr_d, frame_rdy_d;
  logic [2:0]         idx_d;
  logic               tick;
  logic [CNT_W-1:0]   count;
  logic [63:0]        src_frame;
  logic [7:0]         slot_seg;
  word_t              norm_word;
  word_t              blank_word;

  led7seg_tick_gen #(
    .PERIOD (DIGIT_PERIOD),
    .CNT_W  (CNT_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick_c (tick),
    .count  (count)
  );

  // A pending frame becomes visible from the digit-0 word of the swap slot.
  assign src_frame  = (digit_idx == 3'd0 && !frame_rdy) ? shadow_q : active_q;
  assign slot_seg   = blank_mask[digit_idx] ? BLANK_CODE : src_frame[{digit_idx, 3'b000} +: 8];
  assign norm_word  = '{seg: slot_seg,   sel: onehot8(digit_idx)};
  assign blank_word = '{seg: BLANK_CODE, sel: onehot8(digit_idx)};

`ifdef LED7SEG_DIM_EN
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] dim_thr;
  assign dim_thr = CNT_W'((32'(bright) + 32'd1) * (DIGIT_PERIOD / 8));
`endif

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    dat_d       = dat;
    vld_d       = vld;
    idx_d       = digit_idx;
    done_d      = 1'b0;
    ovr_d       = overrun;
    frame_rdy_d = frame_rdy;
`ifdef LED7SEG_DIM_EN
    blank_d     = blank_q;
`endif

    if (frame_vld && frame_rdy) begin
      shadow_d    = frame_seg;
      frame_rdy_d = 1'b0;
    end

    if (state_q == SEND && tick) begin
      ovr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (tick) begin
          state_d = SEND;
          dat_d   = norm_word;
          vld_d   = 1'b1;
`ifdef LED7SEG_DIM_EN
          blank_d = 1'b0;
`endif
          if (digit_idx == 3'd0 && !frame_rdy) begin
            active_d    = shadow_q;
            frame_rdy_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (rdy) begin
          vld_d = 1'b0;
`ifdef LED7SEG_DIM_EN
          if (!blank_q && bright != 3'd7 && enable) begin
            state_d = BLANK;
          end else
`endif
          begin
            done_d = (digit_idx == 3'd7);
            if (enable) begin
              state_d = WAIT;
              idx_d   = 3'(digit_idx + 3'd1);
            end else begin
              state_d = IDLE;
              idx_d   = 3'd0;
            end
          end
        end
      end
`ifdef LED7SEG_DIM_EN
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (count >= dim_thr) begin
          state_d = SEND;
          dat_d   = blank_word;
          vld_d   = 1'b1;
          blank_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      active_q   <= {NUM_DIGITS{BLANK_CODE}};
      shadow_q   <= '0;
      dat        <= '0;
      vld        <= 1'b0;
      digit_idx  <= 3'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      frame_rdy  <= 1'b1;
`ifdef LED7SEG_DIM_EN
      blank_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      dat        <= dat_d;
      vld        <= vld_d;
      digit_idx  <= idx_d;
      frame_done <= done_d;
      overrun    <= ovr_d;
      frame_rdy  <= frame_rdy_d;
`ifdef LED7SEG_DIM_EN
      blank_q    <= blank_d;
`endif
    end
  end

`ifndef LED7SEG_DIM_EN
  logic unused_count;
  assign unused_count = ^{count, blank_word};
`endif

endmodule

// File: tb/tb_led7seg_scan_scheduler.sv
// Directed bench for led7seg_scan_scheduler with DIGIT_PERIOD = 16.
module tb_led7seg_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [63:0] frame_seg;
  logic [7:0]  blank_mask;
  logic        frame_vld;
  logic        frame_rdy;
  logic [15:0] dat;
  logic        vld;
  logic        rdy;
  logic [2:0]  digit_idx;
  logic        frame_done;
  logic        overrun;
  logic [2:0]  bright;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_cyc;
  int bad;
  logic [63:0] f_cur;
  logic [15:0] held;

  localparam logic [63:0] F_BLANK = {8{8'hFF}};
  localparam logic [63:0] F_T2    = 64'hFFFF_FFFF_A4FF_FFC0;
  localparam logic [63:0] F_FULL  = 64'hF882_9299_B0A4_F9C0;

  led7seg_scan_scheduler #(.DIGIT_PERIOD(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
`ifdef LED7SEG_DIM_EN
    .bright     (bright),
`endif
    .frame_seg  (frame_seg),
    .blank_mask (blank_mask),
    .frame_vld  (frame_vld),
    .frame_rdy  (frame_rdy),
    .dat        (dat),
    .vld        (vld),
    .rdy        (rdy),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n = n + 1;
    end while (vld !== 1'b1 && n < 64);
    check({tag, " vld"}, 64'(vld), 64'd1);
  endtask

  function automatic logic [15:0] exp_word(input logic [63:0] f, input logic [7:0] m, input int d);
    logic [7:0] s;
    logic [7:0] sel;
    s   = m[d] ? 8'hFF : f[8*d +: 8];
    sel = 8'(1 << d);
    return {s, sel};
  endfunction

  initial begin
    rst = 1'b0; enable = 1'b0; rdy = 1'b1; frame_vld = 1'b0;
    frame_seg = '0; blank_mask = 8'h00; bright = 3'd7;
    last_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset vld", 64'(vld), 64'd0);
    check("reset dat", 64'(dat), 64'd0);
    check("reset digit_idx", 64'(digit_idx), 64'd0);
    check("reset frame_rdy", 64'(frame_rdy), 64'd1);
    check("reset overrun", 64'(overrun), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b1;

    // Blank scan after reset, one word every 16 cycles.
    f_cur = F_BLANK;
    for (int d = 0; d < 8; d++) begin
      wait_vld($sformatf("t1 d%0d", d));
      check($sformatf("t1 word d%0d", d), 64'(dat), 64'(exp_word(f_cur, 8'h00, d)));
      check($sformatf("t1 idx d%0d", d), 64'(digit_idx), 64'(d));
      if (d > 0) check("t1 spacing", 64'(cyc - last_cyc), 64'd16);
      last_cyc = cyc;
    end
    @(posedge clk);
    #1;
    check("t1 frame_done", 64'(frame_done), 64'd1);
    check("t1 vld drop", 64'(vld), 64'd0);

    // Frame accepted during digit 2 must not tear the current scan.
    for (int d = 0; d < 8; d++) begin
      wait_vld($sformatf("t2a d%0d", d));
      check($sformatf("t2a word d%0d", d), 64'(dat), 64'(exp_word(F_BLANK, 8'h00, d)));
      if (d == 2) begin
        frame_seg = F_T2;
        frame_vld = 1'b1;
        @(posedge clk);
        #1;
        frame_vld = 1'b0;
        check("t2 frame_rdy after accept", 64'(frame_rdy), 64'd0);
      end
      if (d == 7) check("t2 frame_rdy before swap", 64'(frame_rdy), 64'd0);
    end
    for (int d = 0; d < 8; d++) begin
      wait_vld($sformatf("t2b d%0d", d));
      check($sformatf("t2b word d%0d", d), 64'(dat), 64'(exp_word(F_T2, 8'h00, d)));
      if (d == 0) check("t2 frame_rdy after swap", 64'(frame_rdy), 64'd1);
    end
    check("t2 hand d0", 64'(exp_word(F_T2, 8'h00, 0)), 64'h0000_0000_0000_C001);

    // Full frame with the lower four digits masked.
    frame_seg = F_FULL;
    frame_vld = 1'b1;
    blank_mask = 8'h0F;
    @(posedge clk);
    #1;
    frame_vld = 1'b0;
    for (int d = 0; d < 8; d++) begin
      wait_vld($sformatf("t4 d%0d", d));
      check($sformatf("t4 word d%0d", d), 64'(dat), 64'(exp_word(F_FULL, 8'h0F, d)));
    end
    blank_mask = 8'h00;
    @(posedge clk);
    #1;
    rdy = 1'b0;

    // Controller stalls for 40 cycles: word held, overrun flagged, no skip.
    wait_vld("t3");
    check("t3 word", 64'(dat), 64'h0000_0000_0000_C001);
    held = dat;
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (vld !== 1'b1 || dat !== held) bad = bad + 1;
    end
    check("t3 hold cycles bad", 64'(bad), 64'd0);
    check("t3 overrun", 64'(overrun), 64'd1);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    check("t3 vld drop", 64'(vld), 64'd0);
    check("t3 idx", 64'(digit_idx), 64'd1);
    wait_vld("t3 next");
    check("t3 next word", 64'(dat), 64'h0000_0000_0000_F902);

    // Disable while a word is in flight.
    @(posedge clk);
    #1;
    rdy = 1'b0;
    wait_vld("t5");
    check("t5 word", 64'(dat), 64'h0000_0000_0000_A404);
    enable = 1'b0;
    held = dat;
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (vld !== 1'b1 || dat !== held) bad = bad + 1;
    end
    check("t5 hold cycles bad", 64'(bad), 64'd0);
    check("t5 idx held", 64'(digit_idx), 64'd2);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    check("t5 vld drop", 64'(vld), 64'd0);
    check("t5 idx idle", 64'(digit_idx), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5 idle quiet", 64'(vld), 64'd0);
    enable = 1'b1;
    wait_vld("t5 restart");
    check("t5 restart word", 64'(dat), 64'h0000_0000_0000_C001);

    // Async reset while a word is presented.
    @(posedge clk);
    #1;
    rdy = 1'b0;
    wait_vld("t6");
    check("t6 word", 64'(dat), 64'h0000_0000_0000_F902);
    #2;
    rst = 1'b0;
    #1;
    check("t6 vld async", 64'(vld), 64'd0);
    check("t6 dat async", 64'(dat), 64'd0);
    check("t6 overrun cleared", 64'(overrun), 64'd0);
    check("t6 idx", 64'(digit_idx), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    wait_vld("t6 after");
    check("t6 blank after reset", 64'(dat), 64'h0000_0000_0000_FF01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
